// File: rtl/pixel_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers
// (pixel counters, sync pads, blanking logic).
interface pixel_timing_gen_if;

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;

  logic          enable;
  logic          pixel_inc;
  logic          cnt_rst_n;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;

  // Timing generator side: consumes run/freeze, drives all timing
  modport master (
    input  enable,
    output pixel_inc,
    output cnt_rst_n,
    output hsync,
    output vsync,
    output active,
    output line_start,
    output frame_start,
    output h_pos,
    output v_pos
  );

  // Consumer side: controls run/freeze, observes timing
  modport slave (
    output enable,
    input  pixel_inc,
    input  cnt_rst_n,
    input  hsync,
    input  vsync,
    input  active,
    input  line_start,
    input  frame_start,
    input  h_pos,
    input  v_pos
  );

endinterface

// File: rtl/pixel_timing_gen.sv
// Master video timing source. Divides clk into pixel ticks, walks one raster
// (active, front porch, sync, back porch on both axes) and emits the
// pixel_inc / cnt_rst_n pair that keeps downstream pixel counters aligned.
module pixel_timing_gen #(
  parameter int unsigned X_MAX    = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned Y_MAX    = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  pixel_timing_gen_if.master tim
);

  localparam int unsigned HW      = 12;
  localparam int unsigned VW      = 11;
  localparam int unsigned H_TOTAL = X_MAX + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = Y_MAX + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);

  // Illegal parameter sets stop elaboration rather than build a broken raster
  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("pixel_timing_gen: CLK_DIV must be 2 or more");
    end
    if (H_TOTAL > 4096) begin : g_bad_h_total
      $error("pixel_timing_gen: horizontal total exceeds 4096");
    end
    if (V_TOTAL > 2048) begin : g_bad_v_total
      $error("pixel_timing_gen: vertical total exceeds 2048");
    end
    if (X_MAX == 0 || Y_MAX == 0) begin : g_bad_active
      $error("pixel_timing_gen: active area must be non-empty");
    end
  endgenerate

  typedef enum logic [1:0] {
    HS_ACT,
    HS_FP,
    HS_SYNC,
    HS_BP
  } h_state_t;

  typedef enum logic [1:0] {
    VS_ACT,
    VS_FP,
    VS_SYNC,
    VS_BP
  } v_state_t;

  // Horizontal region that a given position belongs to
  function automatic h_state_t h_state_of(input logic [HW-1:0] h);
    int unsigned hi;
    hi = 32'(h);
    if (hi < X_MAX)                        return HS_ACT;
    else if (hi < X_MAX + H_FP)            return HS_FP;
    else if (hi < X_MAX + H_FP + H_SYNC)   return HS_SYNC;
    else                                   return HS_BP;
  endfunction

  // Vertical region that a given line belongs to
  function automatic v_state_t v_state_of(input logic [VW-1:0] v);
    int unsigned vi;
    vi = 32'(v);
    if (vi < Y_MAX)                        return VS_ACT;
    else if (vi < Y_MAX + V_FP)            return VS_FP;
    else if (vi < Y_MAX + V_FP + V_SYNC)   return VS_SYNC;
    else                                   return VS_BP;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  h_state_t         r_h_st;
  v_state_t         r_v_st;
  logic             r_pixel_inc;
  logic             r_cnt_rst_n;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_pre_active;
  logic [HW-1:0]    w_h_nxt;
  logic [VW-1:0]    w_v_nxt;
  h_state_t         w_h_st_nxt;
  v_state_t         w_v_st_nxt;

  // Tick and next raster position derived from the current one
  assign w_tick       = tim.enable && (r_div == DIV_LAST);
  assign w_h_wrap     = (r_h == H_LAST);
  assign w_v_wrap     = w_h_wrap && (r_v == V_LAST);
  assign w_h_nxt      = w_h_wrap ? '0 : r_h + HW'(1);
  assign w_v_nxt      = w_v_wrap ? '0 : (w_h_wrap ? r_v + VW'(1) : r_v);
  assign w_h_st_nxt   = h_state_of(w_h_nxt);
  assign w_v_st_nxt   = v_state_of(w_v_nxt);
  // The pixel being left by this tick lies inside the visible area
  assign w_pre_active = (r_h_st == HS_ACT) && (r_v_st == VS_ACT);

  // Pixel clock divider; holds its phase while frozen so resume is seamless
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (tim.enable) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  // Raster FSMs and registered outputs, advanced once per pixel tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_h_st        <= HS_ACT;
      r_v_st        <= VS_ACT;
      r_pixel_inc   <= 1'b0;
      r_cnt_rst_n   <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_tick) begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_h_st        <= w_h_st_nxt;
      r_v_st        <= w_v_st_nxt;
      r_pixel_inc   <= w_pre_active;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      r_hsync       <= (w_h_st_nxt == HS_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_st_nxt == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_active      <= (w_h_st_nxt == HS_ACT) && (w_v_st_nxt == VS_ACT);
      // x counter is held at 0 for the whole horizontal sync interval
      r_cnt_rst_n   <= (w_h_st_nxt != HS_SYNC);
    end else begin
      // Pulses last one clk; levels hold between ticks and while frozen
      r_pixel_inc   <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign tim.pixel_inc   = r_pixel_inc;
  assign tim.cnt_rst_n   = r_cnt_rst_n;
  assign tim.hsync       = r_hsync;
  assign tim.vsync       = r_vsync;
  assign tim.active      = r_active;
  assign tim.line_start  = r_line_start;
  assign tim.frame_start = r_frame_start;
  assign tim.h_pos       = r_h;
  assign tim.v_pos       = r_v;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench for pixel_timing_gen on a tiny 8 x 6 raster (4x3 active),
// CLK_DIV=2, so one frame is 48 ticks / 96 clks.
module tb_pixel_timing_gen;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pixel_timing_gen_if u_if ();

  pixel_timing_gen #(
    .X_MAX   (4),
    .H_FP    (1),
    .H_SYNC  (2),
    .H_BP    (1),
    .Y_MAX   (3),
    .V_FP    (1),
    .V_SYNC  (1),
    .V_BP    (1),
    .CLK_DIV (2),
    .SYNC_POL(1'b1)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .tim  (u_if)
  );

  always #5 clk = ~clk;

  // Advance one clk and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.enable = 1'b0;
    repeat (3) step();
    checks++;
    if (u_if.h_pos !== 12'd0 || u_if.v_pos !== 11'd0) begin
      errors++;
      $display("FAIL reset_pos h=%0d v=%0d want h=0 v=0", u_if.h_pos, u_if.v_pos);
    end
    checks++;
    if ({u_if.pixel_inc, u_if.cnt_rst_n, u_if.hsync, u_if.vsync, u_if.active,
         u_if.line_start, u_if.frame_start} !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_outputs got pi=%b crn=%b hs=%b vs=%b act=%b ls=%b fs=%b want all 0",
               u_if.pixel_inc, u_if.cnt_rst_n, u_if.hsync, u_if.vsync, u_if.active,
               u_if.line_start, u_if.frame_start);
    end
  endtask

  // Two frames from reset release: first-line pulse pattern, per-frame
  // counts, frame marker, and an X_MAX=4 wrapping pixel counter fed by the DUT
  task automatic test_frame();
    logic [15:0] first_pulses;
    int   pulse_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt, act_cnt;
    int   consec, bad_ls, bad_fall, x;
    logic prev_pi, prev_crn;
    first_pulses = '0;
    pulse_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0; act_cnt = 0;
    consec = 0; bad_ls = 0; bad_fall = 0; x = 0;
    prev_pi = 1'b0; prev_crn = 1'b0;
    reset = 1'b0;
    u_if.enable = 1'b1;
    for (int k = 1; k <= 192; k++) begin
      step();
      if (k <= 16) first_pulses[k-1] = u_if.pixel_inc;
      if (k == 1) begin
        checks++;
        if (u_if.h_pos !== 12'd0 || u_if.cnt_rst_n !== 1'b0) begin
          errors++;
          $display("FAIL first_clk h=%0d crn=%b want h=0 crn=0", u_if.h_pos, u_if.cnt_rst_n);
        end
      end
      if (k == 2) begin
        checks++;
        if (u_if.h_pos !== 12'd1 || u_if.cnt_rst_n !== 1'b1 || u_if.active !== 1'b1) begin
          errors++;
          $display("FAIL first_tick h=%0d crn=%b act=%b want h=1 crn=1 act=1",
                   u_if.h_pos, u_if.cnt_rst_n, u_if.active);
        end
      end
      if (k == 96) begin
        checks++;
        if (u_if.frame_start !== 1'b1 || u_if.line_start !== 1'b1 ||
            u_if.h_pos !== 12'd0 || u_if.v_pos !== 11'd0) begin
          errors++;
          $display("FAIL frame_wrap fs=%b ls=%b h=%0d v=%0d want fs=1 ls=1 h=0 v=0",
                   u_if.frame_start, u_if.line_start, u_if.h_pos, u_if.v_pos);
        end
      end
      if (k <= 96) begin
        pulse_cnt += int'(u_if.pixel_inc);
        hs_cnt    += int'(u_if.hsync);
        vs_cnt    += int'(u_if.vsync);
        ls_cnt    += int'(u_if.line_start);
        fs_cnt    += int'(u_if.frame_start);
        act_cnt   += int'(u_if.active);
      end
      if (prev_pi && u_if.pixel_inc) consec++;
      if (u_if.line_start && x != 0) bad_ls++;
      if (prev_crn && !u_if.cnt_rst_n && x != 0) bad_fall++;
      prev_pi  = u_if.pixel_inc;
      prev_crn = u_if.cnt_rst_n;
      if (!u_if.cnt_rst_n) x = 0;
      else if (u_if.pixel_inc) x = (x == 3) ? 0 : x + 1;
    end
    checks++;
    if (first_pulses !== 16'h00AA) begin
      errors++;
      $display("FAIL first_line_pulses got %h want 00aa", first_pulses);
    end
    checks++;
    if (pulse_cnt != 12) begin
      errors++;
      $display("FAIL frame_pixel_inc got %0d want 12", pulse_cnt);
    end
    checks++;
    if (hs_cnt != 24) begin
      errors++;
      $display("FAIL frame_hsync_clks got %0d want 24", hs_cnt);
    end
    checks++;
    if (vs_cnt != 16) begin
      errors++;
      $display("FAIL frame_vsync_clks got %0d want 16", vs_cnt);
    end
    checks++;
    if (ls_cnt != 6 || fs_cnt != 1) begin
      errors++;
      $display("FAIL frame_markers line_start=%0d frame_start=%0d want 6 and 1", ls_cnt, fs_cnt);
    end
    checks++;
    if (act_cnt != 23) begin
      errors++;
      $display("FAIL frame_active_clks got %0d want 23", act_cnt);
    end
    checks++;
    if (consec != 0) begin
      errors++;
      $display("FAIL pixel_inc_back_to_back got %0d want 0", consec);
    end
    checks++;
    if (bad_ls != 0 || bad_fall != 0) begin
      errors++;
      $display("FAIL pixel_counter_align bad_line_start=%0d bad_sync_entry=%0d want 0 and 0",
               bad_ls, bad_fall);
    end
  endtask

  // Freeze for 7 clks mid-line with the divider half way, then resume
  task automatic test_enable_gap();
    int   pulses, gap_bad;
    logic [7:0] resume_pulses;
    pulses = 0; gap_bad = 0; resume_pulses = '0;
    repeat (5) begin
      step();
      pulses += int'(u_if.pixel_inc);
    end
    checks++;
    if (u_if.h_pos !== 12'd2 || u_if.v_pos !== 11'd0 || u_if.pixel_inc !== 1'b0) begin
      errors++;
      $display("FAIL pre_gap h=%0d v=%0d pi=%b want h=2 v=0 pi=0",
               u_if.h_pos, u_if.v_pos, u_if.pixel_inc);
    end
    u_if.enable = 1'b0;
    repeat (7) begin
      step();
      if (u_if.h_pos !== 12'd2 || u_if.v_pos !== 11'd0 || u_if.pixel_inc !== 1'b0 ||
          u_if.line_start !== 1'b0 || u_if.frame_start !== 1'b0 || u_if.active !== 1'b1)
        gap_bad++;
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL gap_frozen bad_clks=%0d want 0", gap_bad);
    end
    u_if.enable = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      resume_pulses[r-1] = u_if.pixel_inc;
      pulses += int'(u_if.pixel_inc);
      if (r == 1) begin
        checks++;
        if (u_if.h_pos !== 12'd3) begin
          errors++;
          $display("FAIL resume_first_tick h=%0d want 3", u_if.h_pos);
        end
      end
    end
    checks++;
    if (resume_pulses !== 8'h05) begin
      errors++;
      $display("FAIL resume_pulses got %h want 05", resume_pulses);
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL gap_line_pulses got %0d want 4", pulses);
    end
    checks++;
    if (u_if.h_pos !== 12'd6 || u_if.hsync !== 1'b1) begin
      errors++;
      $display("FAIL resume_position h=%0d hs=%b want h=6 hs=1", u_if.h_pos, u_if.hsync);
    end
  endtask

  // Reset deep in vertical sync, then confirm restart from the origin
  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (u_if.h_pos == 12'd5 && u_if.v_pos == 11'd4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_h5_v4 got h=%0d v=%0d want h=5 v=4 within 200 clks",
               u_if.h_pos, u_if.v_pos);
    end else begin
      checks++;
      if (u_if.hsync !== 1'b1 || u_if.vsync !== 1'b1 || u_if.cnt_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL sync_at_h5_v4 hs=%b vs=%b crn=%b want 1 1 0",
                 u_if.hsync, u_if.vsync, u_if.cnt_rst_n);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (u_if.h_pos !== 12'd0 || u_if.v_pos !== 11'd0 ||
        {u_if.pixel_inc, u_if.cnt_rst_n, u_if.hsync, u_if.vsync, u_if.active,
         u_if.line_start, u_if.frame_start} !== 7'b0000000) begin
      errors++;
      $display("FAIL mid_frame_reset h=%0d v=%0d pi=%b crn=%b hs=%b vs=%b act=%b want all 0",
               u_if.h_pos, u_if.v_pos, u_if.pixel_inc, u_if.cnt_rst_n, u_if.hsync,
               u_if.vsync, u_if.active);
    end
    reset = 1'b0;
    step();
    checks++;
    if (u_if.h_pos !== 12'd0 || u_if.v_pos !== 11'd0 || u_if.pixel_inc !== 1'b0) begin
      errors++;
      $display("FAIL restart_clk1 h=%0d v=%0d pi=%b want 0 0 0",
               u_if.h_pos, u_if.v_pos, u_if.pixel_inc);
    end
    step();
    checks++;
    if (u_if.h_pos !== 12'd1 || u_if.v_pos !== 11'd0 || u_if.pixel_inc !== 1'b1) begin
      errors++;
      $display("FAIL restart_clk2 h=%0d v=%0d pi=%b want 1 0 1",
               u_if.h_pos, u_if.v_pos, u_if.pixel_inc);
    end
  endtask

  initial begin
    reset = 1'b1;
    u_if.enable = 1'b0;
    test_reset();
    test_frame();
    test_enable_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
